id_scoreboard: RTL and testbench

In-order issue scoreboard that controls the decode stage's issue of instructions to execute. It sits beside the decode stage and holds an ordered in-flight queue of destination registers written by issued instructions. It grants or stalls each issue request on register hazards and queue occupancy. It retires queue entries on writeback and discards squashed entries on a pipeline flush.

---
 rtl/id_scoreboard.sv | 148 ++++++++++++++
 tb/tb_id_scoreboard.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// ----------------------------------------------------------------------------
// id_scoreboard
//   In-order issue scoreboard beside the decode stage. It keeps an ordered
//   circular queue of destination registers of in-flight writing
//   instructions. Each issue request is granted or stalled on register
//   hazards and queue occupancy. The oldest entry retires on writeback, and
//   younger entries are discarded on a flush.
//
//   Optional feature macro: SCOREBOARD_RAW_CHECK_EN
//     defined   : hazard also covers RAW (nonzero rs1/rs2 match a valid entry)
//     undefined : hazard covers WAW on rd only
//
// Parameters
//   DEPTH          maximum in-flight writing instructions (2..8)
//   CW             width of the occupancy and keep counts (derived)
//
// Ports
//   clk            clock, rising-edge
//   rst_i          asynchronous active-high reset
//   issue_req_i    decode holds an instruction ready for execute
//   issue_rd_i     destination register of the request
//   issue_rs1_i    source register 1 of the request
//   issue_rs2_i    source register 2 of the request
//   issue_grant_o  issue accepted this cycle (combinational)
//   wb_valid_i     writeback writes the register file this cycle
//   wb_rd_i        register written by writeback
//   flush_i        squash younger in-flight instructions
//   flush_keep_i   number of oldest entries surviving the flush
//   count_o        queue occupancy
//   full_o         queue holds DEPTH entries
//   err_o          sticky protocol error
// ----------------------------------------------------------------------------
module id_scoreboard #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic          issue_req_i,
    input  logic [4:0]    issue_rd_i,
    input  logic [4:0]    issue_rs1_i,
    input  logic [4:0]    issue_rs2_i,
    output logic          issue_grant_o,
    input  logic          wb_valid_i,
    input  logic [4:0]    wb_rd_i,
    input  logic          flush_i,
    input  logic [CW-1:0] flush_keep_i,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          err_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]    r_q [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_err;

    logic          w_hazard;
    logic          w_full;
    logic          w_grant;
    logic          w_retire;
    logic          w_pop;
    logic          w_push;
    logic          w_err_now;
    logic [PW-1:0] w_head_nxt;
    logic [CW-1:0] w_rem;
    logic [CW-1:0] w_kept;
    logic [PW-1:0] w_idx;

    // Pointer advance modulo DEPTH; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] ptr,
                                               input logic [CW-1:0] n);
        int unsigned s;
        s = (int'(ptr) + int'(n)) % DEPTH;
        return PW'(s);
    endfunction

    // Only slots within 'count' of the head hold valid entries.
    always_comb begin
        w_hazard = 1'b0;
        w_idx    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_idx = wrap_add(r_head, CW'(k));
            if (32'(r_count) > k) begin
                if ((issue_rd_i != '0) && (r_q[w_idx] == issue_rd_i))
                    w_hazard = 1'b1;
`ifdef SCOREBOARD_RAW_CHECK_EN
                if ((issue_rs1_i != '0) && (r_q[w_idx] == issue_rs1_i))
                    w_hazard = 1'b1;
                if ((issue_rs2_i != '0) && (r_q[w_idx] == issue_rs2_i))
                    w_hazard = 1'b1;
`endif
            end
        end
    end

`ifndef SCOREBOARD_RAW_CHECK_EN
    // Sources only matter when RAW checking is built in.
    logic w_unused_src;
    assign w_unused_src = ^{issue_rs1_i, issue_rs2_i};
`endif

    always_comb begin
        w_full     = (r_count == CW'(DEPTH));
        w_grant    = issue_req_i & ~rst_i & ~flush_i & ~w_hazard
                   & ~(w_full & (issue_rd_i != '0));
        w_push     = w_grant & (issue_rd_i != '0);
        w_retire   = wb_valid_i & (wb_rd_i != '0);
        w_pop      = w_retire & (r_count != '0);
        w_err_now  = w_retire & ((r_count == '0) || (r_q[r_head] != wb_rd_i));
        w_head_nxt = w_pop ? wrap_add(r_head, CW'(1)) : r_head;
        // Flush acts on what remains after the same-cycle retire.
        w_rem      = r_count - CW'(w_pop);
        w_kept     = (flush_keep_i < w_rem) ? flush_keep_i : w_rem;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_q[i] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_head <= w_head_nxt;
            if (w_err_now) r_err <= 1'b1;
            if (flush_i) begin
                r_tail  <= wrap_add(w_head_nxt, w_kept);
                r_count <= w_kept;
            end else begin
                if (w_push) begin
                    r_q[r_tail] <= issue_rd_i;
                    r_tail      <= wrap_add(r_tail, CW'(1));
                end
                r_count <= w_rem + CW'(w_push);
            end
        end
    end

    assign issue_grant_o = w_grant;
    assign count_o       = r_count;
    assign full_o        = w_full;
    assign err_o         = r_err;

endmodule

// File: tb/tb_id_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_id_scoreboard
//   Directed scenarios followed by randomized traffic. Expected grant, count,
//   full and err values come from a queue-based reference model of the
//   scoreboard rules kept in this bench.
// ----------------------------------------------------------------------------
module tb_id_scoreboard;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_i;
    logic          issue_req_i;
    logic [4:0]    issue_rd_i, issue_rs1_i, issue_rs2_i;
    logic          issue_grant_o;
    logic          wb_valid_i;
    logic [4:0]    wb_rd_i;
    logic          flush_i;
    logic [CW-1:0] flush_keep_i;
    logic [CW-1:0] count_o;
    logic          full_o;
    logic          err_o;

    id_scoreboard #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .issue_req_i   (issue_req_i),
        .issue_rd_i    (issue_rd_i),
        .issue_rs1_i   (issue_rs1_i),
        .issue_rs2_i   (issue_rs2_i),
        .issue_grant_o (issue_grant_o),
        .wb_valid_i    (wb_valid_i),
        .wb_rd_i       (wb_rd_i),
        .flush_i       (flush_i),
        .flush_keep_i  (flush_keep_i),
        .count_o       (count_o),
        .full_o        (full_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: oldest entry at index 0.
    logic [4:0] mq[$];
    logic       merr;

    function automatic logic in_q(input logic [4:0] r);
        foreach (mq[i]) if (mq[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_grant(input logic req, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic fl);
        logic hz;
        hz = (rd != 0) && in_q(rd);
`ifdef SCOREBOARD_RAW_CHECK_EN
        hz = hz || ((rs1 != 0) && in_q(rs1)) || ((rs2 != 0) && in_q(rs2));
`endif
        return req && !fl && !hz && !((mq.size() == DEPTH) && (rd != 0));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(count_o), 32'(mq.size()));
        check({tag, ".full"},  32'(full_o),  32'(mq.size() == DEPTH));
        check({tag, ".err"},   32'(err_o),   32'(merr));
    endtask

    // One cycle: drive after the falling edge, check grant before the rising
    // edge, advance the model on the edge, check registered state after it.
    task automatic step(input string tag, input logic req, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic wbv, input logic [4:0] wbrd,
                        input logic fl, input int keep);
        logic g;
        @(negedge clk);
        issue_req_i = req; issue_rd_i = rd; issue_rs1_i = rs1; issue_rs2_i = rs2;
        wb_valid_i = wbv; wb_rd_i = wbrd; flush_i = fl; flush_keep_i = CW'(keep);
        #1;
        g = m_grant(req, rd, rs1, rs2, fl);
        check({tag, ".grant"}, 32'(issue_grant_o), 32'(g));
        @(posedge clk);
        if (wbv && wbrd != 0) begin
            if (mq.size() == 0) merr = 1'b1;
            else begin
                if (mq[0] != wbrd) merr = 1'b1;
                void'(mq.pop_front());
            end
        end
        if (fl) while (mq.size() > keep) void'(mq.pop_back());
        if (g && rd != 0) mq.push_back(rd);
        #1;
        check_state(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_i = 1'b1;
        issue_req_i = 1'b1; issue_rd_i = 5'd3; issue_rs1_i = 0; issue_rs2_i = 0;
        wb_valid_i = 0; wb_rd_i = 0; flush_i = 0; flush_keep_i = '0;
        mq.delete(); merr = 1'b0;
        #1;
        check({tag, ".rst_grant"}, 32'(issue_grant_o), 32'(0));
        check_state({tag, ".rst"});
        @(negedge clk);
        rst_i = 1'b0;
        issue_req_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0;
        issue_req_i = 0; issue_rd_i = 0; issue_rs1_i = 0; issue_rs2_i = 0;
        wb_valid_i = 0; wb_rd_i = 0; flush_i = 0; flush_keep_i = '0;
        mq.delete(); merr = 1'b0;

        // WAW stall until writeback, grant the cycle after
        do_reset("t1");
        step("t1.iss5",  1, 5, 0, 0, 0, 0, 0, 0);
        check("t1.cnt1", 32'(count_o), 32'(1));
        step("t1.stall", 1, 5, 0, 0, 0, 0, 0, 0);
        step("t1.wbsame",1, 5, 0, 0, 1, 5, 0, 0);
        step("t1.after", 1, 5, 0, 0, 0, 0, 0, 0);

        // Fill, stall on full, same-cycle retire does not unblock, rd=0 passes
        do_reset("t2");
        for (int i = 1; i <= 4; i++) step("t2.fill", 1, 5'(i), 0, 0, 0, 0, 0, 0);
        check("t2.full", 32'(full_o), 32'(1));
        step("t2.stall", 1, 6, 0, 0, 0, 0, 0, 0);
        step("t2.wb1",   1, 6, 0, 0, 1, 1, 0, 0);
        step("t2.grant", 1, 6, 0, 0, 0, 0, 0, 0);
        check("t2.cnt4", 32'(count_o), 32'(4));
        step("t2.rd0",   1, 0, 0, 0, 0, 0, 0, 0);
        step("t2.pushpop_rd0", 1, 0, 0, 0, 1, 2, 0, 0);

        // Flush keeping 1 of 7,8,9
        do_reset("t3");
        step("t3.i7", 1, 7, 0, 0, 0, 0, 0, 0);
        step("t3.i8", 1, 8, 0, 0, 0, 0, 0, 0);
        step("t3.i9", 1, 9, 0, 0, 0, 0, 0, 0);
        step("t3.fl", 1, 5, 0, 0, 0, 0, 1, 1);
        check("t3.cnt1", 32'(count_o), 32'(1));
        step("t3.r8", 1, 8, 0, 0, 0, 0, 0, 0);
        step("t3.r7", 1, 7, 0, 0, 0, 0, 0, 0);

        // Flush with same-cycle retire, keep 2 and saturating keep 3
        for (int kk = 2; kk <= 3; kk++) begin
            do_reset("t4");
            step("t4.i7", 1, 7, 0, 0, 0, 0, 0, 0);
            step("t4.i8", 1, 8, 0, 0, 0, 0, 0, 0);
            step("t4.i9", 1, 9, 0, 0, 0, 0, 0, 0);
            step("t4.fl", 0, 0, 0, 0, 1, 7, 1, kk);
            check("t4.cnt2", 32'(count_o), 32'(2));
            step("t4.wb8", 0, 0, 0, 0, 1, 8, 0, 0);
            step("t4.wb9", 0, 0, 0, 0, 1, 9, 0, 0);
        end

        // Errors: writeback on empty queue, and head mismatch; both sticky
        do_reset("t5");
        step("t5.wbempty", 0, 0, 0, 0, 1, 4, 0, 0);
        check("t5.err", 32'(err_o), 32'(1));
        idle("t5.sticky");
        do_reset("t5b");
        step("t5b.i3", 1, 3, 0, 0, 0, 0, 0, 0);
        step("t5b.mis",0, 0, 0, 0, 1, 9, 0, 0);
        check("t5b.err", 32'(err_o), 32'(1));
        idle("t5b.sticky");

        // RAW on rs2 (stalls only with the macro defined)
        do_reset("t6");
        step("t6.i10", 1, 10, 0, 0, 0, 0, 0, 0);
        step("t6.raw", 1, 11, 0, 10, 0, 0, 0, 0);

        // Randomized traffic
        for (int seg = 0; seg < 4; seg++) begin
            do_reset("rnd");
            for (int c = 0; c < 300; c++) begin
                logic       req, wbv, fl;
                logic [4:0] rd, rs1, rs2, wbrd;
                int         keep;
                req  = ($urandom_range(0, 99) < 70);
                rd   = 5'($urandom_range(0, 9));
                rs1  = 5'($urandom_range(0, 12));
                rs2  = 5'($urandom_range(0, 12));
                wbv  = ($urandom_range(0, 99) < 40);
                if (mq.size() != 0 && $urandom_range(0, 99) < 97) wbrd = mq[0];
                else wbrd = 5'($urandom_range(0, 9));
                fl   = ($urandom_range(0, 99) < 6);
                keep = $urandom_range(0, (1 << CW) - 1);
                step("rnd", req, rd, rs1, rs2, wbv, wbrd, fl, keep);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
